// File: rtl/gray_sync_decoder_pkg.sv
// Shared types and constants for the Gray-code synchronizer/decoder.
package gray_sync_decoder_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

endpackage

// File: rtl/gray_sync_decoder_if.sv
// Signal bundle between the Gray-code source/consumer and the decoder.
interface gray_sync_decoder_if
  import gray_sync_decoder_pkg::*;
#(
  parameter int WIDTH = 4
);

  logic                 gray_in;
  logic [WIDTH-1:0]     gray_in_w;
  logic                 clr_err;
  logic                 valid;
  logic [WIDTH-1:0]     gray_sync;
  logic [WIDTH-1:0]     bin_out;
  logic                 changed;
  logic [WIDTH-1:0]     delta;
  logic                 step_err;
  logic [ERR_CNT_W-1:0] err_count;

  // Driver side: supplies the Gray value and the error-count clear.
  modport master (
    output gray_in_w, clr_err,
    input  valid, gray_sync, bin_out, changed, delta, step_err, err_count
  );

  // Decoder side.
  modport slave (
    input  gray_in_w, clr_err,
    output valid, gray_sync, bin_out, changed, delta, step_err, err_count
  );

endinterface

// File: rtl/gray_sync_decoder_gray_to_bin.sv
// Pure combinational Gray-to-binary decode: each binary bit is the XOR of
// all Gray bits at and above its position.
module gray_sync_decoder_gray_to_bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // One reduction XOR per output bit keeps the decode free of bit-to-bit loops.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_sync_decoder.sv
// Synchronizes an asynchronous Gray-coded value into clk, decodes it to
// binary and reports per-sample change, signed step and illegal jumps.
//
// state    | meaning
// ST_INIT  | priming the synchronizer after reset; step outputs forced to 0
// ST_TRACK | outputs valid; changes, deltas and step errors are reported
module gray_sync_decoder
  import gray_sync_decoder_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst,
  gray_sync_decoder_if.slave bus
);

  localparam int PRIME_W = $clog2(SYNC_STAGES + 1);

  logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]     gray_prev;
  logic [WIDTH-1:0]     bin_new;
  logic [WIDTH-1:0]     bin_prev;
  logic [WIDTH-1:0]     bin_q;
  logic                 is_changed;
  logic                 is_multi;
  state_t               state;
  logic [PRIME_W-1:0]   prime_cnt;
  logic                 valid_q;
  logic                 changed_q;
  logic [WIDTH-1:0]     delta_q;
  logic                 step_err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  gray_sync_decoder_gray_to_bin #(.WIDTH(WIDTH)) u_dec_new (
    .gray (sync_q[SYNC_STAGES-1]),
    .bin  (bin_new)
  );

  gray_sync_decoder_gray_to_bin #(.WIDTH(WIDTH)) u_dec_prev (
    .gray (gray_prev),
    .bin  (bin_prev)
  );

  // Sample-to-sample comparison; more than one flipped bit is an illegal Gray step.
  always_comb begin
    is_changed = (sync_q[SYNC_STAGES-1] != gray_prev);
    is_multi   = ($countones(sync_q[SYNC_STAGES-1] ^ gray_prev) > 1);
  end

  // Synchronizer chain, previous-sample register and binary output.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      gray_prev <= '0;
      bin_q     <= '0;
    end else begin
      sync_q[0] <= bus.gray_in_w;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      gray_prev <= sync_q[SYNC_STAGES-1];
      bin_q     <= bin_new;
    end
  end

  // Control FSM: primes the chain after reset, then tracks and counts errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_INIT;
      prime_cnt  <= '0;
      valid_q    <= 1'b0;
      changed_q  <= 1'b0;
      delta_q    <= '0;
      step_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          valid_q    <= 1'b0;
          changed_q  <= 1'b0;
          delta_q    <= '0;
          step_err_q <= 1'b0;
          if (prime_cnt == PRIME_W'(SYNC_STAGES)) state <= ST_TRACK;
          else prime_cnt <= prime_cnt + 1'b1;
        end
        ST_TRACK: begin
          valid_q    <= 1'b1;
          changed_q  <= is_changed;
          delta_q    <= is_changed ? (bin_new - bin_prev) : '0;
          step_err_q <= is_multi;
          // A clear coinciding with an error leaves that error counted.
          if (bus.clr_err) err_cnt_q <= is_multi ? ERR_CNT_W'(1) : '0;
          else if (is_multi && (err_cnt_q != ERR_CNT_MAX)) err_cnt_q <= err_cnt_q + 1'b1;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  assign bus.valid     = valid_q;
  assign bus.gray_sync = sync_q[SYNC_STAGES-1];
  assign bus.bin_out   = bin_q;
  assign bus.changed   = changed_q;
  assign bus.delta     = delta_q;
  assign bus.step_err  = step_err_q;
  assign bus.err_count = err_cnt_q;

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Directed bench for gray_sync_decoder (WIDTH=4, SYNC_STAGES=2).
module tb_gray_sync_decoder;
  import gray_sync_decoder_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  gray_sync_decoder_if #(.WIDTH(4)) bus ();

  gray_sync_decoder #(.WIDTH(4), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.gray_in = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  initial begin
    logic [3:0] cur;
    logic [3:0] nb;

    rst = 1'b1;
    bus.gray_in_w = 4'b0110;
    bus.clr_err   = 1'b0;
    repeat (3) tick();
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_bin", 32'(bus.bin_out), 32'd0);
    check("rst_gsync", 32'(bus.gray_sync), 32'd0);
    check("rst_err", 32'(bus.err_count), 32'd0);

    // Release: valid low on edges 1-3, high at edge 4
    rst = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check("prime_valid", 32'(bus.valid), 32'd0);
      check("prime_changed", 32'(bus.changed), 32'd0);
    end
    tick();
    check("e4_valid", 32'(bus.valid), 32'd1);
    check("e4_bin", 32'(bus.bin_out), 32'h4);
    check("e4_changed", 32'(bus.changed), 32'd0);
    check("e4_step_err", 32'(bus.step_err), 32'd0);
    check("e4_delta", 32'(bus.delta), 32'd0);
    check("e4_err", 32'(bus.err_count), 32'd0);

    // Upward walk from bin 4 through the 15->0 wrap, ending at bin 2
    cur = 4'd4;
    for (int s = 0; s < 30; s++) begin
      nb = cur + 4'd1;
      bus.gray_in_w = to_gray(nb);
      tick();
      tick();
      check("walk_early", 32'(bus.changed), 32'd0);
      tick();
      check("walk_changed", 32'(bus.changed), 32'd1);
      check("walk_delta", 32'(bus.delta), 32'h1);
      check("walk_bin", 32'(bus.bin_out), 32'(nb));
      check("walk_step_err", 32'(bus.step_err), 32'd0);
      tick();
      check("walk_pulse_end", 32'(bus.changed), 32'd0);
      check("walk_delta_zero", 32'(bus.delta), 32'd0);
      cur = nb;
    end
    check("walk_err", 32'(bus.err_count), 32'd0);

    // Reverse step 0011 -> 0001 (bin 2 -> 1)
    bus.gray_in_w = 4'b0001;
    repeat (3) tick();
    check("rev_changed", 32'(bus.changed), 32'd1);
    check("rev_delta", 32'(bus.delta), 32'hF);
    check("rev_step_err", 32'(bus.step_err), 32'd0);
    check("rev_bin", 32'(bus.bin_out), 32'h1);
    tick();
    bus.gray_in_w = 4'b0000;
    repeat (3) tick();
    check("rev0_delta", 32'(bus.delta), 32'hF);
    check("rev0_bin", 32'(bus.bin_out), 32'h0);
    tick();

    // Illegal jump 0000 -> 0011
    bus.gray_in_w = 4'b0011;
    tick();
    tick();
    check("ill_pre", 32'(bus.step_err), 32'd0);
    tick();
    check("ill_step_err", 32'(bus.step_err), 32'd1);
    check("ill_bin", 32'(bus.bin_out), 32'h2);
    check("ill_delta", 32'(bus.delta), 32'h2);
    check("ill_err", 32'(bus.err_count), 32'd1);
    tick();
    check("ill_pulse_end", 32'(bus.step_err), 32'd0);
    check("ill_err_hold", 32'(bus.err_count), 32'd1);

    // 300 more illegal jumps: counter saturates
    for (int i = 0; i < 300; i++) begin
      bus.gray_in_w = (i % 2 == 0) ? 4'b0000 : 4'b0011;
      tick();
    end
    repeat (3) tick();
    check("sat_err", 32'(bus.err_count), 32'd255);
    check("sat_step_err", 32'(bus.step_err), 32'd0);

    // clr_err together with step_err, then clr_err alone
    bus.gray_in_w = 4'b0000;
    tick();
    tick();
    bus.clr_err = 1'b1;
    tick();
    check("clr_both_step", 32'(bus.step_err), 32'd1);
    check("clr_both_err", 32'(bus.err_count), 32'd1);
    bus.clr_err = 1'b0;
    tick();
    check("clr_hold_err", 32'(bus.err_count), 32'd1);
    bus.clr_err = 1'b1;
    tick();
    check("clr_alone_err", 32'(bus.err_count), 32'd0);
    bus.clr_err = 1'b0;

    // Make the counter nonzero, step legally, then reset mid-walk
    bus.gray_in_w = 4'b0011;
    repeat (4) tick();
    check("pre_rst_err", 32'(bus.err_count), 32'd1);
    bus.gray_in_w = 4'b0010;
    tick();
    bus.gray_in_w = 4'b1100;
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 32'(bus.valid), 32'd0);
    check("mid_rst_bin", 32'(bus.bin_out), 32'd0);
    check("mid_rst_changed", 32'(bus.changed), 32'd0);
    check("mid_rst_delta", 32'(bus.delta), 32'd0);
    check("mid_rst_step_err", 32'(bus.step_err), 32'd0);
    check("mid_rst_err", 32'(bus.err_count), 32'd0);
    check("mid_rst_gsync", 32'(bus.gray_sync), 32'd0);
    rst = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check("re_prime_valid", 32'(bus.valid), 32'd0);
      check("re_prime_changed", 32'(bus.changed), 32'd0);
      check("re_prime_step_err", 32'(bus.step_err), 32'd0);
    end
    tick();
    check("re_valid", 32'(bus.valid), 32'd1);
    check("re_bin", 32'(bus.bin_out), 32'h8);
    check("re_changed", 32'(bus.changed), 32'd0);
    check("re_step_err", 32'(bus.step_err), 32'd0);
    check("re_err", 32'(bus.err_count), 32'd0);
    tick();
    check("re_changed2", 32'(bus.changed), 32'd0);
    check("re_step_err2", 32'(bus.step_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
